// File: rtl/contactor_sequencer.sv
// Closes up to eight contactors one at a time: command, wait for auxiliary feedback,
// settle, then move on round-robin. Opens and permit-loss trips act on any contactor at once.
module contactor_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned SETTLE_CYC  = 50
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_req,
    input  logic [7:0] i_fb,
    input  logic [7:0] i_permit,
    input  logic       i_fault_clr,
    output logic [7:0] o_cmd,
    output logic       o_busy,
    output logic [7:0] o_deny,
    output logic [7:0] o_done,
    output logic [7:0] o_trip,
    output logic       o_fault,
    output logic [2:0] o_fault_idx,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_FB = 2'd1,
        SETTLE  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  ptr;
    logic [2:0]  idx;

    logic [7:0]  pending;
    logic        found;
    logic [2:0]  sel;
    logic [2:0]  cand;
    logic [7:0]  sel_mask;
    logic [7:0]  idx_mask;
    logic [7:0]  held;
    logic [7:0]  lost;
    logic [7:0]  trip_next;
    logic [7:0]  cmd_kept;

    // The contactor still waiting for feedback is not "held" yet, so it cannot trip.
    always_comb begin
        pending = i_req & ~o_cmd;
        found   = 1'b0;
        sel     = 3'd0;
        cand    = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && pending[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        sel_mask = 8'b1 << sel;
        idx_mask = 8'b1 << idx;
        held     = o_cmd;
        if (state == WAIT_FB) begin
            held = o_cmd & ~idx_mask;
        end
        lost      = held & ~i_permit;
        trip_next = lost & i_req;
        cmd_kept  = o_cmd & i_req & ~lost;
    end

    assign o_busy  = (state == WAIT_FB) || (state == SETTLE);
    assign o_state = state;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_cmd       <= 8'h00;
            o_deny      <= 8'h00;
            o_done      <= 8'h00;
            o_trip      <= 8'h00;
            o_fault     <= 1'b0;
            o_fault_idx <= 3'd0;
            cnt         <= 16'd0;
            ptr         <= 3'd7;
            idx         <= 3'd0;
        end else begin
            o_cmd  <= cmd_kept;
            o_deny <= 8'h00;
            o_done <= 8'h00;
            o_trip <= trip_next;
            case (state)
                IDLE: begin
                    if (found) begin
                        if (i_permit[sel]) begin
                            o_cmd <= cmd_kept | sel_mask;
                            idx   <= sel;
                            cnt   <= 16'd0;
                            state <= WAIT_FB;
                        end else begin
                            o_deny <= sel_mask;
                            ptr    <= sel;
                        end
                    end
                end
                WAIT_FB: begin
                    if (!i_req[idx]) begin
                        ptr   <= idx;
                        state <= IDLE;
                    end else if (i_fb[idx]) begin
                        cnt   <= 16'd0;
                        state <= SETTLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        o_cmd       <= cmd_kept & ~idx_mask;
                        o_fault     <= 1'b1;
                        o_fault_idx <= idx;
                        state       <= FAULT;
                    end else if (cnt != 16'hFFFF) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SETTLE: begin
                    if (!i_req[idx]) begin
                        ptr   <= idx;
                        state <= IDLE;
                    end else if (lost[idx]) begin
                        state <= IDLE;
                    end else if (cnt == SETTLE_LAST) begin
                        o_done <= idx_mask;
                        ptr    <= idx;
                        state  <= IDLE;
                    end else if (cnt != 16'hFFFF) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                FAULT: begin
                    if (i_fault_clr) begin
                        o_fault     <= 1'b0;
                        o_fault_idx <= 3'd0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_contactor_sequencer.sv
// Directed bench for contactor_sequencer: close sequencing, round-robin order,
// permit denial, feedback timeout, trips, aborts and reset behaviour.
module tb_contactor_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] permit;
    logic       fault_clr;
    logic       fb_auto;
    logic [7:0] fb_man;
    logic [7:0] fb;
    logic [7:0] cmd;
    logic       busy;
    logic [7:0] deny;
    logic [7:0] done;
    logic [7:0] trip;
    logic       fault;
    logic [2:0] fault_idx;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // Plant model: auxiliary contacts either mirror the command instantly or are driven by hand.
    assign fb = fb_auto ? cmd : fb_man;

    always #5 clk = ~clk;

    contactor_sequencer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_fb        (fb),
        .i_permit    (permit),
        .i_fault_clr (fault_clr),
        .o_cmd       (cmd),
        .o_busy      (busy),
        .o_deny      (deny),
        .o_done      (done),
        .o_trip      (trip),
        .o_fault     (fault),
        .o_fault_idx (fault_idx),
        .o_state     (state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req       = 8'h00;
        permit    = 8'hFF;
        fault_clr = 1'b0;
        fb_auto   = 1'b0;
        fb_man    = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done == 8'h00 && n < 300);
    endtask

    task automatic test_reset();
        apply_reset();
        rst_n  = 1'b0;
        req    = 8'hFF;
        fb_man = 8'hFF;
        tick();
        tick();
        checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd: got %h want 00", cmd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({deny, done, trip} !== 24'h0) begin errors++; $display("FAIL reset_pulses: got %h want 000000", {deny, done, trip}); end
        checks++; if ({fault, fault_idx} !== 4'h0) begin errors++; $display("FAIL reset_fault: got %h want 0", {fault, fault_idx}); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        rst_n  = 1'b1;
        req    = 8'h00;
        fb_man = 8'h00;
        tick();
    endtask

    task automatic test_single();
        int n;
        apply_reset();
        req = 8'h01;
        tick();
        checks++; if (cmd !== 8'h01) begin errors++; $display("FAIL single_cmd: got %h want 01", cmd); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        repeat (4) tick();
        fb_man = 8'h01;
        // One edge to register feedback, then SETTLE_CYC=50 dwell edges.
        wait_done(n);
        checks++; if (n !== 51) begin errors++; $display("FAIL single_latency: got %0d want 51", n); end
        checks++; if (done !== 8'h01) begin errors++; $display("FAIL single_done: got %h want 01", done); end
        tick();
        checks++; if (done !== 8'h00) begin errors++; $display("FAIL single_done_width: got %h want 00", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy); end
        checks++; if (cmd !== 8'h01) begin errors++; $display("FAIL single_hold: got %h want 01", cmd); end
        req = 8'h00;
        tick();
        checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL single_open: got %h want 00", cmd); end
    endtask

    task automatic test_round_robin();
        int n;
        apply_reset();
        fb_auto = 1'b1;
        req = 8'h05;
        tick();
        checks++; if (cmd !== 8'h01) begin errors++; $display("FAIL rr_first: got %h want 01", cmd); end
        wait_done(n);
        checks++; if (done !== 8'h01) begin errors++; $display("FAIL rr_done_a: got %h want 01", done); end
        checks++; if (cmd !== 8'h01) begin errors++; $display("FAIL rr_c_waits: got %h want 01", cmd); end
        tick();
        checks++; if (cmd !== 8'h05) begin errors++; $display("FAIL rr_second: got %h want 05", cmd); end
        wait_done(n);
        checks++; if (done !== 8'h04) begin errors++; $display("FAIL rr_done_c: got %h want 04", done); end
        // Search resumes after C, so D comes before B.
        req = 8'h0F;
        tick();
        checks++; if (cmd !== 8'h0D) begin errors++; $display("FAIL rr_third: got %h want 0d", cmd); end
        wait_done(n);
        checks++; if (done !== 8'h08) begin errors++; $display("FAIL rr_done_d: got %h want 08", done); end
        tick();
        checks++; if (cmd !== 8'h0F) begin errors++; $display("FAIL rr_fourth: got %h want 0f", cmd); end
        wait_done(n);
        checks++; if (done !== 8'h02) begin errors++; $display("FAIL rr_done_b: got %h want 02", done); end
    endtask

    task automatic test_deny();
        apply_reset();
        permit = 8'hFB;
        req    = 8'h04;
        tick();
        checks++; if (deny !== 8'h04) begin errors++; $display("FAIL deny_pulse: got %h want 04", deny); end
        checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL deny_cmd: got %h want 00", cmd); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL deny_state: got %0d want 0", state); end
    endtask

    task automatic test_timeout();
        int n;
        apply_reset();
        req = 8'h02;
        tick();
        checks++; if (cmd !== 8'h02) begin errors++; $display("FAIL to_cmd: got %h want 02", cmd); end
        n = 0;
        do begin
            tick();
            n++;
        end while (fault !== 1'b1 && n < 1200);
        checks++; if (n !== 1000) begin errors++; $display("FAIL to_latency: got %0d want 1000", n); end
        checks++; if (fault_idx !== 3'd1) begin errors++; $display("FAIL to_idx: got %0d want 1", fault_idx); end
        checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL to_cmd_clr: got %h want 00", cmd); end
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL to_state: got %0d want 3", state); end
        req = 8'h03;
        repeat (5) tick();
        checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL to_ignore: got %h want 00", cmd); end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL to_latched: got %b want 1", fault); end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        checks++; if ({fault, fault_idx} !== 4'h0) begin errors++; $display("FAIL to_clear: got %h want 0", {fault, fault_idx}); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL to_clr_state: got %0d want 0", state); end
        tick();
        checks++; if (cmd !== 8'h01) begin errors++; $display("FAIL to_resume: got %h want 01", cmd); end
    endtask

    task automatic test_trip();
        int n;
        int seen;
        apply_reset();
        fb_auto = 1'b1;
        req = 8'h03;
        wait_done(n);
        checks++; if (done !== 8'h01) begin errors++; $display("FAIL trip_done_a: got %h want 01", done); end
        wait_done(n);
        checks++; if (done !== 8'h02) begin errors++; $display("FAIL trip_done_b: got %h want 02", done); end
        tick();
        checks++; if (cmd !== 8'h03) begin errors++; $display("FAIL trip_held: got %h want 03", cmd); end
        permit = 8'hFE;
        tick();
        checks++; if (cmd !== 8'h02) begin errors++; $display("FAIL trip_cmd: got %h want 02", cmd); end
        checks++; if (trip !== 8'h01) begin errors++; $display("FAIL trip_pulse: got %h want 01", trip); end
        tick();
        checks++; if (trip !== 8'h00) begin errors++; $display("FAIL trip_width: got %h want 00", trip); end
        permit = 8'hFC;
        req    = 8'h00;
        tick();
        checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL trip_both_cmd: got %h want 00", cmd); end
        checks++; if (trip !== 8'h00) begin errors++; $display("FAIL trip_both_pulse: got %h want 00", trip); end
        permit = 8'hFF;
        req    = 8'h04;
        tick();
        checks++; if (cmd !== 8'h04) begin errors++; $display("FAIL abort_cmd: got %h want 04", cmd); end
        tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL abort_settle: got %0d want 2", state); end
        repeat (10) tick();
        req = 8'h00;
        tick();
        checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL abort_open: got %h want 00", cmd); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d want 0", state); end
        seen = 0;
        repeat (60) begin
            if (done !== 8'h00) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", seen); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        fb_auto = 1'b1;
        req = 8'h01;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL rmid_cmd: got %h want 00", cmd); end
        checks++; if ({done, fault} !== 9'h0) begin errors++; $display("FAIL rmid_flags: got %h want 000", {done, fault}); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rmid_state: got %0d want 0", state); end
        rst_n = 1'b1;
        req   = 8'h00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_deny();
        test_timeout();
        test_trip();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
